// File: rtl/keypad_scan_event.sv
// 4x4 keypad scanner: row rotation, per-key frame debounce, press strobes and an event queue.
// Define KEYPAD_EVENT_FIFO_EN for a 4-entry event FIFO; otherwise a single holding register is used.
module keypad_scan_event #(
  parameter int CNT_SCAN   = 60000,
  parameter int DEBOUNCE_N = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] key_out,
  output logic [15:0] key_pulse,
  output logic        ev_valid,
  output logic [3:0]  ev_code,
  input  logic        ev_ready,
  output logic        ev_overflow
);

  localparam int CW = (CNT_SCAN > 1) ? $clog2(CNT_SCAN) : 1;

  logic [CW-1:0] dwell;
  logic [1:0]    row_idx;
  logic [15:0]   raw;
  logic [15:0]   raw_now;
  logic [3:0]    dbc [16];
  logic          tc;
  logic          frame_end;
  logic          push;
  logic          pop;
  logic [3:0]    push_code;

  // Dwell runs as a down-counter; terminal count at zero gives CNT_SCAN cycles per row.
  assign tc        = (dwell == '0);
  assign frame_end = tc && (row_idx == 2'd3);
  assign row       = ~(4'b0001 << row_idx);

  // Debounce must see the sample being latched on the frame-end edge itself.
  always_comb begin
    raw_now = raw;
    raw_now[{row_idx, 2'b00} +: 4] = ~col;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= CW'(CNT_SCAN - 1);
      row_idx   <= 2'd0;
      raw       <= '0;
      key_out   <= '0;
      key_pulse <= '0;
      for (int i = 0; i < 16; i++) dbc[i] <= '0;
    end else begin
      key_pulse <= '0;
      if (tc) begin
        dwell   <= CW'(CNT_SCAN - 1);
        raw     <= raw_now;
        row_idx <= row_idx + 2'd1;
      end else begin
        dwell <= dwell - 1'b1;
      end
      if (frame_end) begin
        for (int i = 0; i < 16; i++) begin
          if (raw_now[i] != key_out[i]) begin
            if (dbc[i] == 4'(DEBOUNCE_N - 1)) begin
              key_out[i]   <= raw_now[i];
              key_pulse[i] <= raw_now[i];
              dbc[i]       <= '0;
            end else begin
              dbc[i] <= dbc[i] + 4'd1;
            end
          end else begin
            dbc[i] <= '0;
          end
        end
      end
    end
  end

  // Simultaneous presses collapse into one event carrying the lowest key index.
  always_comb begin
    push_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (key_pulse[i]) push_code = 4'(i);
    end
  end

  assign push = |key_pulse;
  assign pop  = ev_valid && ev_ready;

`ifdef KEYPAD_EVENT_FIFO_EN
  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       full;
  logic       push_ok;

  assign full    = (count == 3'd4);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      count       <= 3'd0;
      ev_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) ev_overflow <= 1'b1;
    end
  end

  assign ev_valid = (count != 3'd0);
  assign ev_code  = ev_valid ? mem[rd_ptr] : 4'd0;
`else
  logic       hold_valid;
  logic [3:0] hold_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid  <= 1'b0;
      hold_code   <= 4'd0;
      ev_overflow <= 1'b0;
    end else begin
      if (push && (!hold_valid || pop)) begin
        hold_valid <= 1'b1;
        hold_code  <= push_code;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
      if (push && hold_valid && !pop) ev_overflow <= 1'b1;
    end
  end

  assign ev_valid = hold_valid;
  assign ev_code  = hold_valid ? hold_code : 4'd0;
`endif

endmodule
